cpu_multicycle_ctrl: RTL and testbench
======================================

Name: cpu_multicycle_ctrl

Overview:
- Multi-cycle control unit for the next-generation 24-bit CPU; replaces the single-cycle combinational control path.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, issuing one control word per cycle to a shared-ALU, shared-memory datapath.
- Holds in memory states until the memory handshake completes.
- Opcode and funct widths are parametrised. Adds BNE, ADDI, HALT and illegal-opcode detection.

Parameters:
OPCODE_W, 4, opcode field width
FUNCT_W, 4, funct field width
ALUOP_W, 2, ALU-op bus width (minimum 2)
CNT_W, 32, performance counter width (used only with the optional feature)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
opcode  input  OPCODE_W  from instruction register
funct  input  FUNCT_W  from instruction register (passed through for R-type ALU decode)
zero  input  1  ALU zero flag
mem_ready  input  1  memory handshake: read/write completes in the cycle this is high
mem_read, mem_write  output  1  memory strobes
i_or_d  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
ir_write, pc_write  output  1  register enables
pc_src  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 = rt, 01 = const 1, 10 = sign-extended immediate
alu_op  output  ALUOP_W  00 = add, 01 = sub, 10 = use funct
reg_dst, reg_write, mem_to_reg  output  1  register-file controls
instr_done  output  1  one-cycle pulse when an instruction retires
illegal  output  1  one-cycle pulse when an undefined opcode is decoded
halted  output  1  high while in HALT
cycle_count, instr_count  output  CNT_W  performance counters

Behaviour:
- Opcodes are zero-extended to OPCODE_W: 0 = R-type, 1 = ADDI, 2 = LW, 3 = SW, 4 = BEQ, 5 = BNE, 6 = J; all-ones = HALT. Every other value is illegal.
- Reset: state <= FETCH. While Reset is high, all outputs are 0 and the counters are cleared. A Reset mid-instruction abandons that instruction; no strobe is issued in the Reset cycle.
- Outputs are a combinational decode of the state; in FETCH/MEM_RD/MEM_WR they are additionally qualified by mem_ready.
- FETCH: mem_read = 1, i_or_d = 0. Stay while mem_ready = 0. When mem_ready = 1: ir_write = 1, pc_write = 1, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00, then go to DECODE.
- DECODE: alu_src_b = 10, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - R-type -> EXEC_R
  - ADDI -> EXEC_I
  - LW or SW -> MEM_ADDR
  - BEQ or BNE -> BRANCH
  - J -> JUMP
  - HALT -> HALT
  - illegal -> FETCH, with illegal = 1 for this cycle
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> R_WB. R_WB: reg_dst = 1, reg_write = 1, instr_done = 1 -> FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> I_WB. I_WB: reg_dst = 0, reg_write = 1, instr_done = 1 -> FETCH.
- MEM_ADDR: same ALU controls as EXEC_I -> MEM_RD if LW, MEM_WR if SW.
- MEM_RD: mem_read = 1, i_or_d = 1; hold until mem_ready = 1 -> MEM_WB. MEM_WB: mem_to_reg = 1, reg_write = 1, instr_done = 1 -> FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1; hold until mem_ready = 1, then instr_done = 1 -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01. pc_write = zero for BEQ, ~zero for BNE. instr_done = 1 -> FETCH.
- JUMP: pc_src = 10, pc_write = 1, instr_done = 1 -> FETCH.
- HALT: halted = 1, all strobes 0. Sticky until Reset.
- Cycle counts with zero-wait memory: R-type/ADDI/SW 4, LW 5, BEQ/BNE/J 3. Each wait cycle adds exactly 1.
- Any undefined state encoding -> FETCH.

Optional Feature:
- CTRL_PERF_CNT_EN defined:
  - cycle_count increments every non-Reset cycle while not halted.
  - instr_count increments on each instr_done.
  - Both wrap modulo 2^CNT_W.
- Undefined: no counter registers; both ports are driven constant 0.

Decomposition:
- Package cpu_ctrl_pkg: state enum, opcode constants, alu_op and pc_src encodings, control-word struct.
- Sub-module ctrl_word_decode: purely combinational, (state, opcode, zero, mem_ready) -> control word.
- The top level holds the state register, next-state logic and the optional counters.

Test Plan:
- Reset then R-type (opcode 0, funct 3), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, R_WB; instr_done in cycle 4; alu_op = 10 in EXEC_R.
- LW with mem_ready low for 2 cycles in both FETCH and MEM_RD -> instruction takes 9 cycles; mem_read held throughout each wait; ir_write pulses exactly once.
- BEQ with zero = 1, then BNE with zero = 1 -> pc_write = 1 in BRANCH for BEQ, 0 for BNE; each instruction takes 3 cycles.
- Opcode 4'hA -> illegal pulse in DECODE, no reg_write/mem_write, back in FETCH next cycle. Opcode 4'hF -> halted = 1 and held for 20 cycles; a Reset pulse returns to FETCH with halted = 0.
- Reset asserted in MEM_WR while mem_ready = 0 -> all outputs 0 in that cycle; FETCH on the next cycle; no mem_write after Reset.
- With CTRL_PERF_CNT_EN: 10 ADDIs at zero wait -> instr_count = 10, cycle_count = 40. Without the macro: both counters read 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control unit: state enum, opcode values,
// ALU-op / PC-source / ALU-B-source encodings and the per-cycle control word.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StRWb     = 4'd3,
        StExecI   = 4'd4,
        StIWb     = 4'd5,
        StMemAddr = 4'd6,
        StMemRd   = 4'd7,
        StMemWb   = 4'd8,
        StMemWr   = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StHalt    = 4'd12
    } state_e;

    // Opcode values before zero-extension to the configured opcode width; HALT is all-ones.
    localparam int unsigned OpRType = 0;
    localparam int unsigned OpAddi  = 1;
    localparam int unsigned OpLw    = 2;
    localparam int unsigned OpSw    = 3;
    localparam int unsigned OpBeq   = 4;
    localparam int unsigned OpBne   = 5;
    localparam int unsigned OpJ     = 6;

    typedef enum logic [3:0] {
        ClsR,
        ClsAddi,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsBne,
        ClsJ,
        ClsHalt,
        ClsIllegal
    } op_class_e;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    localparam logic [1:0] SrcBRt   = 2'b00;
    localparam logic [1:0] SrcBOne  = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
        logic       halted;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_word_decode.sv
// Combinational control-word decode: (state, opcode, zero, mem_ready) -> control word.
// Also exports the opcode class so the sequencer branches on the same decode.
module ctrl_word_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  state_e                state_i,
    input  logic [OPCODE_W-1:0]   opcode_i,
    input  logic                  zero_i,
    input  logic                  mem_ready_i,
    output op_class_e             op_class_o,
    output ctrl_word_t            ctrl_o
);

    op_class_e op_class;

    // Classify the opcode; anything not listed is illegal.
    always_comb begin
        op_class = ClsIllegal;
        if (opcode_i == OPCODE_W'(OpRType)) begin
            op_class = ClsR;
        end else if (opcode_i == OPCODE_W'(OpAddi)) begin
            op_class = ClsAddi;
        end else if (opcode_i == OPCODE_W'(OpLw)) begin
            op_class = ClsLw;
        end else if (opcode_i == OPCODE_W'(OpSw)) begin
            op_class = ClsSw;
        end else if (opcode_i == OPCODE_W'(OpBeq)) begin
            op_class = ClsBeq;
        end else if (opcode_i == OPCODE_W'(OpBne)) begin
            op_class = ClsBne;
        end else if (opcode_i == OPCODE_W'(OpJ)) begin
            op_class = ClsJ;
        end else if (opcode_i == {OPCODE_W{1'b1}}) begin
            op_class = ClsHalt;
        end
    end

    assign op_class_o = op_class;

    // Per-state control word; memory states are further qualified by the handshake.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_read = 1'b1;
                if (mem_ready_i) begin
                    ctrl_o.ir_write  = 1'b1;
                    ctrl_o.pc_write  = 1'b1;
                    ctrl_o.alu_src_b = SrcBOne;
                    ctrl_o.alu_op    = AluAdd;
                    ctrl_o.pc_src    = PcAlu;
                end
            end
            StDecode: begin
                // Branch target is precomputed into ALUOut here.
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluAdd;
                ctrl_o.illegal   = (op_class == ClsIllegal);
            end
            StExecR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBRt;
                ctrl_o.alu_op    = AluFunct;
            end
            StRWb: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StExecI, StMemAddr: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluAdd;
            end
            StIWb: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StMemRd: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            StMemWb: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            StBranch: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SrcBRt;
                ctrl_o.alu_op     = AluSub;
                ctrl_o.pc_src     = PcAluOut;
                ctrl_o.pc_write   = (op_class == ClsBne) ? ~zero_i : zero_i;
                ctrl_o.instr_done = 1'b1;
            end
            StJump: begin
                ctrl_o.pc_src     = PcJump;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StHalt: begin
                ctrl_o.halted = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle control unit top: state register, next-state sequencing and optional performance
// counters. Define CTRL_PERF_CNT_EN to build the cycle/instruction counters; otherwise both
// counter ports are tied to zero.
module cpu_multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned FUNCT_W  = 4,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                i_or_d_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic [1:0]          pc_src_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALUOP_W-1:0]  alu_op_o,
    output logic                reg_dst_o,
    output logic                reg_write_o,
    output logic                mem_to_reg_o,
    output logic                instr_done_o,
    output logic                illegal_o,
    output logic                halted_o,
    output logic [CNT_W-1:0]    cycle_count_o,
    output logic [CNT_W-1:0]    instr_count_o
);

    state_e     state_q, state_d;
    op_class_e  op_class;
    ctrl_word_t ctrl;
    ctrl_word_t ctrl_out;

    // funct only feeds the external ALU control; it is not needed for sequencing.
    logic unused_funct;
    assign unused_funct = ^funct_i;

    ctrl_word_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .op_class_o  (op_class),
        .ctrl_o      (ctrl)
    );

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; unknown encodings recover to FETCH.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = mem_ready_i ? StDecode : StFetch;
            StDecode: begin
                case (op_class)
                    ClsR:           state_d = StExecR;
                    ClsAddi:        state_d = StExecI;
                    ClsLw, ClsSw:   state_d = StMemAddr;
                    ClsBeq, ClsBne: state_d = StBranch;
                    ClsJ:           state_d = StJump;
                    ClsHalt:        state_d = StHalt;
                    default:        state_d = StFetch;
                endcase
            end
            StExecR:   state_d = StRWb;
            StRWb:     state_d = StFetch;
            StExecI:   state_d = StIWb;
            StIWb:     state_d = StFetch;
            StMemAddr: state_d = (op_class == ClsLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = mem_ready_i ? StMemWb : StMemRd;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = mem_ready_i ? StFetch : StMemWr;
            StBranch:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StHalt:    state_d = StHalt;
            default:   state_d = StFetch;
        endcase
    end

    // Output stage: everything is forced low during the reset cycle.
    always_comb begin
        ctrl_out = ctrl;
        if (rst_i) begin
            ctrl_out = '0;
        end
    end

    assign mem_read_o   = ctrl_out.mem_read;
    assign mem_write_o  = ctrl_out.mem_write;
    assign i_or_d_o     = ctrl_out.i_or_d;
    assign ir_write_o   = ctrl_out.ir_write;
    assign pc_write_o   = ctrl_out.pc_write;
    assign pc_src_o     = ctrl_out.pc_src;
    assign alu_src_a_o  = ctrl_out.alu_src_a;
    assign alu_src_b_o  = ctrl_out.alu_src_b;
    assign alu_op_o     = ALUOP_W'(ctrl_out.alu_op);
    assign reg_dst_o    = ctrl_out.reg_dst;
    assign reg_write_o  = ctrl_out.reg_write;
    assign mem_to_reg_o = ctrl_out.mem_to_reg;
    assign instr_done_o = ctrl_out.instr_done;
    assign illegal_o    = ctrl_out.illegal;
    assign halted_o     = ctrl_out.halted;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Counter next-state: cycles advance unless halted, instructions on retirement.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (!ctrl.halted) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (ctrl.instr_done) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_count_o = rst_i ? '0 : cycle_cnt_q;
    assign instr_count_o = rst_i ? '0 : instr_cnt_q;
`else
    assign cycle_count_o = '0;
    assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Bench for cpu_multicycle_ctrl: instruction-level scripts generate the expected control word
// for every cycle, a compare process checks the DUT on each falling edge, plus literal checks
// on instruction lengths and counter totals.
module tb_cpu_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic [3:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_dst, reg_write, mem_to_reg, instr_done, illegal, halted;
    logic [31:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    cpu_multicycle_ctrl #(
        .OPCODE_W (4),
        .FUNCT_W  (4),
        .ALUOP_W  (2),
        .CNT_W    (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .opcode_i      (opcode),
        .funct_i       (funct),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .i_or_d_o      (i_or_d),
        .ir_write_o    (ir_write),
        .pc_write_o    (pc_write),
        .pc_src_o      (pc_src),
        .alu_src_a_o   (alu_src_a),
        .alu_src_b_o   (alu_src_b),
        .alu_op_o      (alu_op),
        .reg_dst_o     (reg_dst),
        .reg_write_o   (reg_write),
        .mem_to_reg_o  (mem_to_reg),
        .instr_done_o  (instr_done),
        .illegal_o     (illegal),
        .halted_o      (halted),
        .cycle_count_o (cycle_count),
        .instr_count_o (instr_count)
    );

    typedef struct packed {
        logic       mr, mw, iod, irw, pcw;
        logic [1:0] pcs;
        logic       asa;
        logic [1:0] asb, aop;
        logic       rd, rw, m2r, done, ill, hlt;
    } cw_t;

    // Phases of an instruction's life as the bench sees them.
    localparam int PhFetch  = 0;
    localparam int PhDecode = 1;
    localparam int PhExecR  = 2;
    localparam int PhRWb    = 3;
    localparam int PhExecI  = 4;
    localparam int PhIWb    = 5;
    localparam int PhMemRd  = 6;
    localparam int PhMemWb  = 7;
    localparam int PhMemWr  = 8;
    localparam int PhBranch = 9;
    localparam int PhJump   = 10;
    localparam int PhHalt   = 11;

    int          vectors = 0;
    int          miscompares = 0;
    cw_t         act;
    cw_t         exp_cw;
    logic [31:0] exp_cyc, exp_ins;
    string       exp_tag;
    bit          exp_valid = 0;
    logic [31:0] m_cyc = 0, m_ins = 0;
    int          run_len = 0, last_len = 0, irw_cnt = 0, last_irw = 0;

    assign act = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                  alu_op, reg_dst, reg_write, mem_to_reg, instr_done, illegal, halted};

    // Control word required in a given phase; 'a' is the phase's data-dependent bit.
    function automatic cw_t want(input int ph, input logic a);
        cw_t e;
        e = '0;
        case (ph)
            PhFetch:  begin e.mr = 1; if (a) begin e.irw = 1; e.pcw = 1; e.asb = 2'b01; end end
            PhDecode: begin e.asb = 2'b10; e.ill = a; end
            PhExecR:  begin e.asa = 1; e.aop = 2'b10; end
            PhRWb:    begin e.rd = 1; e.rw = 1; e.done = 1; end
            PhExecI:  begin e.asa = 1; e.asb = 2'b10; end
            PhIWb:    begin e.rw = 1; e.done = 1; end
            PhMemRd:  begin e.mr = 1; e.iod = 1; end
            PhMemWb:  begin e.m2r = 1; e.rw = 1; e.done = 1; end
            PhMemWr:  begin e.mw = 1; e.iod = 1; e.done = a; end
            PhBranch: begin e.asa = 1; e.aop = 2'b01; e.pcs = 2'b01; e.pcw = a; e.done = 1; end
            PhJump:   begin e.pcs = 2'b10; e.pcw = 1; e.done = 1; end
            PhHalt:   begin e.hlt = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    // One clock cycle: drive inputs, publish the expectation, advance the counter model.
    task automatic step(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                        input cw_t e, input string tag);
        rst = r; opcode = op; zero = z; mem_ready = rdy; funct = 4'($urandom_range(0, 15));
        exp_cw  = r ? '0 : e;
`ifdef CTRL_PERF_CNT_EN
        exp_cyc = r ? 32'd0 : m_cyc;
        exp_ins = r ? 32'd0 : m_ins;
`else
        exp_cyc = 32'd0;
        exp_ins = 32'd0;
`endif
        exp_tag = tag;
        exp_valid = 1;
        @(posedge clk);
        #1;
        if (r) begin
            m_cyc = 0;
            m_ins = 0;
        end else begin
            if (!e.hlt) m_cyc = m_cyc + 1;
            if (e.done) m_ins = m_ins + 1;
        end
    endtask

    task automatic rnd_bit(output logic b);
        b = 1'($urandom_range(0, 1));
    endtask

    // Run one whole instruction with fw fetch waits and mw data-memory waits.
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z,
                             input int halt_cycles);
        logic rb;
        for (int i = 0; i < fw; i++) step(0, op, z, 0, want(PhFetch, 0), "fetch-wait");
        step(0, op, z, 1, want(PhFetch, 1), "fetch");
        rnd_bit(rb);
        step(0, op, z, rb, want(PhDecode, !(op <= 4'd6 || op == 4'hF)), "decode");
        case (op)
            4'd0: begin
                rnd_bit(rb); step(0, op, z, rb, want(PhExecR, 0), "exec-r");
                rnd_bit(rb); step(0, op, z, rb, want(PhRWb, 0), "r-wb");
            end
            4'd1: begin
                rnd_bit(rb); step(0, op, z, rb, want(PhExecI, 0), "exec-i");
                rnd_bit(rb); step(0, op, z, rb, want(PhIWb, 0), "i-wb");
            end
            4'd2: begin
                rnd_bit(rb); step(0, op, z, rb, want(PhExecI, 0), "mem-addr");
                for (int i = 0; i < mw; i++) step(0, op, z, 0, want(PhMemRd, 0), "mem-rd-wait");
                step(0, op, z, 1, want(PhMemRd, 0), "mem-rd");
                rnd_bit(rb); step(0, op, z, rb, want(PhMemWb, 0), "mem-wb");
            end
            4'd3: begin
                rnd_bit(rb); step(0, op, z, rb, want(PhExecI, 0), "mem-addr");
                for (int i = 0; i < mw; i++) step(0, op, z, 0, want(PhMemWr, 0), "mem-wr-wait");
                step(0, op, z, 1, want(PhMemWr, 1), "mem-wr");
            end
            4'd4: begin rnd_bit(rb); step(0, op, z, rb, want(PhBranch, z), "beq"); end
            4'd5: begin rnd_bit(rb); step(0, op, z, rb, want(PhBranch, !z), "bne"); end
            4'd6: begin rnd_bit(rb); step(0, op, z, rb, want(PhJump, 0), "jump"); end
            4'hF: begin
                for (int i = 0; i < halt_cycles; i++) begin
                    rnd_bit(rb); step(0, op, rb, !rb, want(PhHalt, 0), "halt");
                end
                step(1, op, z, 1, want(PhFetch, 0), "halt-reset");
            end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Compare process: control word and counters every cycle, plus observed instruction length.
    always @(negedge clk) begin
        if (exp_valid) begin
            vectors++;
            if (act !== exp_cw) begin
                miscompares++;
                $display("FAIL ctrl[%s] t=%0t: got %h, required %h", exp_tag, $time, act, exp_cw);
            end
            vectors++;
            if (cycle_count !== exp_cyc || instr_count !== exp_ins) begin
                miscompares++;
                $display("FAIL counters[%s] t=%0t: got cyc=%0d ins=%0d, required cyc=%0d ins=%0d",
                         exp_tag, $time, cycle_count, instr_count, exp_cyc, exp_ins);
            end
            if (rst) begin
                run_len = 0;
                irw_cnt = 0;
            end else begin
                run_len++;
                if (ir_write === 1'b1) irw_cnt++;
                if (instr_done === 1'b1) begin
                    last_len = run_len;
                    last_irw = irw_cnt;
                    run_len  = 0;
                    irw_cnt  = 0;
                end
            end
        end
    end

    initial begin
        logic [3:0] op;
        int         sel;
        rst = 1; opcode = 0; funct = 0; zero = 0; mem_ready = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, '0, "reset");
        step(1, 0, 0, 1, '0, "reset");

        run_instr(4'd0, 0, 0, 0, 0);
        check("r-type length", last_len, 4);
        run_instr(4'd2, 2, 2, 0, 0);
        check("lw length with waits", last_len, 9);
        check("lw ir_write pulses", last_irw, 1);
        run_instr(4'd3, 0, 0, 0, 0);
        check("sw length", last_len, 4);
        run_instr(4'd4, 0, 0, 1, 0);
        check("beq length", last_len, 3);
        run_instr(4'd5, 0, 0, 1, 0);
        check("bne length", last_len, 3);
        run_instr(4'd6, 1, 0, 0, 0);
        check("j length one wait", last_len, 4);
        run_instr(4'hA, 0, 0, 0, 0);
        run_instr(4'hF, 0, 0, 0, 20);

        // Reset lands while a store is waiting on memory.
        step(0, 4'd3, 0, 1, want(PhFetch, 1), "fetch");
        step(0, 4'd3, 0, 1, want(PhDecode, 0), "decode");
        step(0, 4'd3, 0, 1, want(PhExecI, 0), "mem-addr");
        step(0, 4'd3, 0, 0, want(PhMemWr, 0), "mem-wr-wait");
        step(1, 4'd3, 0, 0, want(PhMemWr, 0), "reset-in-mem-wr");
        run_instr(4'd0, 0, 0, 0, 0);
        check("r-type after abort", last_len, 4);

        step(1, 0, 0, 0, '0, "reset");
        for (int i = 0; i < 10; i++) run_instr(4'd1, 0, 0, 0, 0);
`ifdef CTRL_PERF_CNT_EN
        check("instr_count after 10 addi", int'(instr_count), 10);
        check("cycle_count after 10 addi", int'(cycle_count), 40);
`else
        check("instr_count disabled", int'(instr_count), 0);
        check("cycle_count disabled", int'(cycle_count), 0);
`endif

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 19);
            if (sel <= 6) op = 4'(sel);
            else if (sel <= 13) op = 4'($urandom_range(7, 14));
            else if (sel <= 18) op = 4'(sel % 7);
            else op = 4'hF;
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 5));
        end

        exp_valid = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
